// File: rtl/q3_13_to_q2_14_q4_12_conv.sv
`default_nettype none
// ============================================================================
// Module   : q3_13_to_q2_14_q4_12_conv
// Brief    : Two-stage valid/ready pipeline that re-expresses a Q(3,13)
//            sample as a saturated Q(2,14) value and a Q(4,12) value
//            (round half-up or truncate), and counts saturated bundles.
// Revision : 1.0 - initial release
// ============================================================================
module q3_13_to_q2_14_q4_12_conv #(
  parameter int unsigned ROUND_EN  = 1,
  parameter int unsigned SAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          q2_14_out,
  output logic [15:0]          q4_12_out,
  output logic                 sat_flag,
  output logic                 lsb_lost,
  output logic [SAT_CNT_W-1:0] sat_count,
  input  logic                 clr_count
);

  localparam logic [SAT_CNT_W-1:0] c_CNT_ONE = {{(SAT_CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 (compute) and stage 2 (output) registers
  logic                 r_s1_valid;
  logic [15:0]          r_s1_q2;
  logic [15:0]          r_s1_q4;
  logic                 r_s1_sat;
  logic                 r_s1_lsb;
  logic                 r_s2_valid;
  logic [15:0]          r_s2_q2;
  logic [15:0]          r_s2_q4;
  logic                 r_s2_sat;
  logic                 r_s2_lsb;
  logic [SAT_CNT_W-1:0] r_sat_count;

  logic                 w_s2_load;
  logic                 w_s1_load;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_sat;
  logic [15:0]          w_q2;
  logic [15:0]          w_q4;

  // Stage 2 accepts whenever it is empty or its bundle leaves this cycle;
  // stage 1 accepts whenever it is empty or it is moving into stage 2.
  // in_ready therefore depends only on registered state, out_ready and rst_n.
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign in_ready   = rst_n && w_s1_load;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  // Doubling fits in 16 bits only when the top two bits agree
  assign w_sat = in_data[15] ^ in_data[14];
  assign w_q2  = w_sat ? (in_data[15] ? 16'h8000 : 16'h7FFF)
                       : {in_data[14:0], 1'b0};

  // Halving: (x + 1) >>> 1 equals (x >>> 1) + x[0], which keeps the sum
  // inside 16 bits because x >>> 1 never exceeds 0x3FFF.
  generate
    if (ROUND_EN != 0) begin : g_round
      assign w_q4 = {in_data[15], in_data[15:1]} + {15'd0, in_data[0]};
    end else begin : g_trunc
      assign w_q4 = {in_data[15], in_data[15:1]};
    end
  endgenerate

  // Stage 1: capture the converted sample when the stage can take new data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_q2    <= 16'd0;
      r_s1_q4    <= 16'd0;
      r_s1_sat   <= 1'b0;
      r_s1_lsb   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_in_fire;
      r_s1_q2    <= w_q2;
      r_s1_q4    <= w_q4;
      r_s1_sat   <= w_sat;
      r_s1_lsb   <= in_data[0];
    end
  end

  // Stage 2: output register, holds its bundle while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_q2    <= 16'd0;
      r_s2_q4    <= 16'd0;
      r_s2_sat   <= 1'b0;
      r_s2_lsb   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      r_s2_q2    <= r_s1_q2;
      r_s2_q4    <= r_s1_q4;
      r_s2_sat   <= r_s1_sat;
      r_s2_lsb   <= r_s1_lsb;
    end
  end

  // Saturation counter: clear wins, otherwise count saturated transfers up to all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (clr_count) begin
      r_sat_count <= '0;
    end else if (w_out_fire && r_s2_sat && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + c_CNT_ONE;
    end
  end

  assign out_valid = r_s2_valid;
  assign q2_14_out = r_s2_q2;
  assign q4_12_out = r_s2_q4;
  assign sat_flag  = r_s2_sat;
  assign lsb_lost  = r_s2_lsb;
  assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: doc/q3_13_to_q2_14_q4_12_conv.md
Name: q3_13_to_q2_14_q4_12_conv

Overview:
- Back-conversion stage for the fixed-point datapath. It takes Q(3,13) results (sum/diff/product from the ops block) and re-expresses each sample in both Q(2,14) and Q(4,12) for downstream consumers.
- Input and output both use a streaming valid/ready handshake.
- Two-stage registered pipeline:
  - Q(2,14) conversion saturates on overflow.
  - Q(4,12) conversion offers optional rounding.
  - Transferred samples that saturated are counted.

Parameters:
- ROUND_EN, 1, 1 = Q(4,12) output rounds half-up (toward +inf); 0 = truncate (arithmetic shift).
- SAT_CNT_W, 8, width of the saturation event counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  16  signed Q(3,13) sample
- out_valid  output  1  output bundle valid
- out_ready  input  1  downstream accepts bundle
- q2_14_out  output  16  signed Q(2,14) result, saturated
- q4_12_out  output  16  signed Q(4,12) result
- sat_flag  output  1  q2_14_out of this bundle was saturated
- lsb_lost  output  1  in_data[0] was 1, so the Q(4,12) conversion discarded a fraction bit
- sat_count  output  SAT_CNT_W  number of saturated bundles transferred out
- clr_count  input  1  synchronous clear of sat_count

Behaviour:
- Reset: synchronous, sampled on rising clk while rst_n=0.
  - Stage valids cleared.
  - out_valid=0, q2_14_out=0, q4_12_out=0, sat_flag=0, lsb_lost=0, sat_count=0.
  - in_ready=0 while rst_n=0.
  - In-flight samples are discarded. No partial bundle appears after reset.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline: S1 (compute register) feeds S2 (output register). S2 drives the out_* ports directly.
  - S2 loads from S1 when S2 is empty or out_ready=1.
  - S1 loads from the input when S1 is empty or S1 is advancing.
  - in_ready = rst_n && !(s1_valid && s2_valid && !out_ready). This is registered-state-only logic with no combinational path from in_valid.
- Latency and throughput:
  - Accepted sample appears on out_* exactly 2 cycles later when out_ready is held 1.
  - Throughput is 1 sample/cycle.
  - Order is preserved. No sample is dropped or duplicated under any out_ready pattern.
- Q(2,14) conversion: value = in_data <<< 1.
  - Representable iff in_data[15] == in_data[14].
  - Otherwise saturate: positive (in_data[15]=0) gives 0x7FFF, negative gives 0x8000, and sat_flag=1.
- Q(4,12) conversion, computed in 17-bit signed, never overflows:
  - ROUND_EN=1: (sext(in_data) + 1) >>> 1.
  - ROUND_EN=0: in_data >>> 1.
  - lsb_lost = in_data[0] in both modes.
- Output holding: out_* hold stable while out_valid=1 && out_ready=0. Values are don't-care but stable when out_valid=0.
- sat_count:
  - Increments by 1 on each output transfer with sat_flag=1.
  - Sticks at all-ones; no wrap.
  - clr_count=1 forces 0 and takes priority over a simultaneous increment.

Test Plan:
- Basic conversion: in_data 0x1000 (0.5), out_ready=1 -> 2 cycles later q2_14_out=0x2000, q4_12_out=0x0800, sat_flag=0, lsb_lost=0.
- Saturation:
  - 0x5000 (2.5) -> q2_14_out=0x7FFF, sat_flag=1, q4_12_out=0x2800.
  - 0xA000 (-3.0) -> q2_14_out=0x8000, sat_flag=1, q4_12_out=0xD000.
  - 0xC000 (-2.0) -> q2_14_out=0x8000, sat_flag=0.
- Rounding:
  - ROUND_EN=1: 0x0003 -> 0x0002; 0xFFFF -> 0x0000; 0x7FFF -> 0x4000.
  - ROUND_EN=0: 0x0003 -> 0x0001; 0xFFFF -> 0xFFFF.
  - lsb_lost=1 for all of the above.
- Backpressure: stream 0x0100..0x0105 back-to-back with out_ready low for 4 cycles after the first out_valid -> in_ready drops once 2 samples are held; bundles stay stable; all 6 outputs emerge in order (q2_14_out 0x0200..0x020A); no loss or duplicates.
- Counter (SAT_CNT_W=8): 300 consecutive 0x6000 inputs -> sat_count=255 and holds. clr_count asserted in the same cycle as a saturated transfer -> sat_count=0 next cycle.
- Reset mid-stream: rst_n=0 for 1 cycle while both stages are full -> next cycle out_valid=0, all outputs 0, in_ready=0 during reset; first post-reset input appears with 2-cycle latency.
